// File: rtl/mig_fifo_pkg.sv
// Shared types and AXI constants for the MIG write-burst engine.
// Holds the burst FSM state encoding and the AxSIZE helper.
package mig_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AxSIZE encoding: log2 of the bytes per beat for a data width in bits.
  function automatic logic [2:0] axsize_f(input int width);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((8 << i) == width) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mig_axi_wr_burst.sv
// Drains an upstream AXIS FIFO into a DDR ring buffer through AXI4 INCR
// write bursts, reporting each committed burst length once BRESP returns.
module mig_axi_wr_burst
  import mig_fifo_pkg::*;
#(
  parameter logic [3:0]  ID_TAG        = 4'd0,
  parameter int          MAX_BURST_LEN = 16,
  parameter logic [31:0] BASE_ADDRESS  = 32'h0,
  parameter int          MEMORY_SIZE   = 1024,
  parameter int          MIG_PORT_SIZE = 128,
  parameter int          FLUSH_DELAY   = 32,
  localparam int         CW            = $clog2(MEMORY_SIZE + 1)
) (
  input  logic                       aclk,
  input  logic                       reset,
  input  logic [MIG_PORT_SIZE-1:0]   s_tdata,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [CW-1:0]              wr_words_avail,
  input  logic [CW-1:0]              mem_free_words,
  output logic [3:0]                 m_axi_awid,
  output logic [31:0]                m_axi_awaddr,
  output logic [7:0]                 m_axi_awlen,
  output logic [2:0]                 m_axi_awsize,
  output logic [1:0]                 m_axi_awburst,
  output logic                       m_axi_awlock,
  output logic [3:0]                 m_axi_awcache,
  output logic [2:0]                 m_axi_awprot,
  output logic [3:0]                 m_axi_awqos,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [MIG_PORT_SIZE-1:0]   m_axi_wdata,
  output logic [MIG_PORT_SIZE/8-1:0] m_axi_wstrb,
  output logic                       m_axi_wlast,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  input  logic [3:0]                 m_axi_bid,
  input  logic [1:0]                 m_axi_bresp,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready,
  output logic                       commit_valid,
  output logic [8:0]                 commit_len,
  output logic                       bresp_err
);

  localparam int         BYTES = MIG_PORT_SIZE / 8;
  localparam int         ICW   = $clog2(FLUSH_DELAY + 2);
  localparam logic [8:0] MAX9  = 9'(MAX_BURST_LEN);

  wr_state_t      state;
  logic [CW-1:0]  wr_ptr;
  logic [ICW-1:0] idle_cnt;
  logic [8:0]     beat_cnt;
  logic [8:0]     len;

  logic [31:0]    ptr_ext;
  logic [31:0]    ptr_sum;
  logic [8:0]     room;
  logic [8:0]     len_next;
  logic           full_avail;
  logic           flush_hit;
  logic           start;
  logic           beat;
  logic [CW-1:0]  ptr_adv;
  logic           unused_bid;

  assign unused_bid = ^m_axi_bid;

  assign m_axi_awid    = ID_TAG;
  assign m_axi_awsize  = axsize_f(MIG_PORT_SIZE);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_wstrb   = '1;

  // Handshake outputs decode directly from the state register, so they
  // drop the cycle after reset is sampled and stay stable within a phase.
  assign m_axi_awvalid = (state == ST_ADDR);
  assign m_axi_bready  = (state == ST_RESP);
  assign m_axi_wdata   = s_tdata;
  assign m_axi_wvalid  = (state == ST_DATA) && s_tvalid;
  assign s_tready      = (state == ST_DATA) && m_axi_wready;
  assign m_axi_wlast   = (state == ST_DATA) && (beat_cnt == len - 9'd1);
  assign beat          = m_axi_wvalid && m_axi_wready;

  always_comb begin
    ptr_ext = 32'(wr_ptr);
    // Words left before the next MAX_BURST_LEN-aligned boundary; with the
    // aligned base this also keeps bursts inside 4 KB and the ring end.
    room = 9'(32'(MAX_BURST_LEN) - (ptr_ext % 32'(MAX_BURST_LEN)));
    len_next = MAX9;
    if (32'(wr_words_avail) < 32'(len_next)) len_next = 9'(wr_words_avail);
    if (32'(mem_free_words) < 32'(len_next)) len_next = 9'(mem_free_words);
    if (room < len_next) len_next = room;
    full_avail = 32'(wr_words_avail) >= 32'(MAX_BURST_LEN);
    flush_hit  = (idle_cnt == ICW'(FLUSH_DELAY));
    start      = (len_next != 9'd0) && (full_avail || flush_hit);
    ptr_sum    = ptr_ext + 32'(len);
    ptr_adv    = (ptr_sum == 32'(MEMORY_SIZE)) ? '0 : CW'(ptr_sum);
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      idle_cnt     <= '0;
      beat_cnt     <= '0;
      len          <= '0;
      m_axi_awaddr <= '0;
      m_axi_awlen  <= '0;
      commit_valid <= 1'b0;
      commit_len   <= '0;
      bresp_err    <= 1'b0;
    end else begin
      commit_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_ADDR;
            len          <= len_next;
            idle_cnt     <= '0;
            beat_cnt     <= '0;
            m_axi_awaddr <= BASE_ADDRESS + ptr_ext * 32'(BYTES);
            m_axi_awlen  <= 8'(len_next - 9'd1);
          end else if (wr_words_avail == '0) begin
            idle_cnt <= '0;
          end else if (!full_avail && !flush_hit) begin
            idle_cnt <= idle_cnt + ICW'(1);
          end
        end
        ST_ADDR: begin
          if (m_axi_awready) begin
            state    <= ST_DATA;
            beat_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (m_axi_wlast) state <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Error responses are flagged but the words still count as written.
          if (m_axi_bvalid) begin
            state        <= ST_IDLE;
            commit_valid <= 1'b1;
            commit_len   <= len;
            wr_ptr       <= ptr_adv;
            if (m_axi_bresp != AXI_RESP_OKAY) bresp_err <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mig_axi_wr_burst.sv
// Randomized bench for mig_axi_wr_burst: a transaction-level model of the
// burst rules checks the DUT every cycle, plus literal scenario checks.
module tb_mig_axi_wr_burst;

  localparam int W  = 128;
  localparam int MB = 16;
  localparam int MS = 64;
  localparam int FD = 32;
  localparam int CW = $clog2(MS + 1);

  logic          aclk = 1'b0;
  logic          reset;
  logic [W-1:0]  s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [CW-1:0] wr_words_avail;
  logic [CW-1:0] mem_free_words;
  logic [3:0]    m_axi_awid;
  logic [31:0]   m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic          m_axi_awlock;
  logic [3:0]    m_axi_awcache;
  logic [2:0]    m_axi_awprot;
  logic [3:0]    m_axi_awqos;
  logic          m_axi_awvalid;
  logic          m_axi_awready;
  logic [W-1:0]  m_axi_wdata;
  logic [W/8-1:0] m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_wvalid;
  logic          m_axi_wready;
  logic [3:0]    m_axi_bid;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid;
  logic          m_axi_bready;
  logic          commit_valid;
  logic [8:0]    commit_len;
  logic          bresp_err;

  always #5 aclk = ~aclk;

  mig_axi_wr_burst #(
    .ID_TAG(4'h3), .MAX_BURST_LEN(MB), .BASE_ADDRESS(32'h0),
    .MEMORY_SIZE(MS), .MIG_PORT_SIZE(W), .FLUSH_DELAY(FD)
  ) dut (
    .aclk(aclk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .wr_words_avail(wr_words_avail), .mem_free_words(mem_free_words),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .commit_valid(commit_valid), .commit_len(commit_len), .bresp_err(bresp_err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Upstream FIFO contents and the order the words must appear on W.
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int  free_words;
  int  tv_pct, wr_pct;
  bit  rand_bresp;
  logic [1:0] bresp_mode;
  bit  pop_req, b_ack;
  int  b_pending;

  // Transaction-level model: 0 waiting, 1 address, 2 data, 3 response.
  int  m_phase, m_ptr, m_len, m_beat, m_cnt;
  bit  m_err, commit_exp, after_rst, aw_first;
  int  commit_exp_len, dut_beats, cyc;

  int  aw_addr_q[$], aw_len_q[$], aw_cyc_q[$];
  int  cm_len_q[$], cm_cyc_q[$], beats_q[$];

  // Upstream FIFO and AXI slave, driven just after each rising edge.
  always @(posedge aclk) begin
    #1;
    if (pop_req) begin
      if (fifo_q.size() > 0) fifo_q.delete(0);
      pop_req  = 1'b0;
      s_tvalid = 1'b0;
    end
    if (!s_tvalid) s_tvalid = (fifo_q.size() > 0) && ($urandom_range(0, 99) < tv_pct);
    s_tdata        = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    wr_words_avail = CW'(fifo_q.size());
    mem_free_words = CW'(free_words);
    m_axi_awready  = ($urandom_range(0, 99) < 60);
    m_axi_wready   = ($urandom_range(0, 99) < wr_pct);
    if (b_ack) begin
      m_axi_bvalid = 1'b0;
      b_ack        = 1'b0;
      b_pending--;
    end
    if (!m_axi_bvalid && b_pending > 0 && $urandom_range(0, 99) < 50) begin
      m_axi_bvalid = 1'b1;
      m_axi_bresp  = rand_bresp ? 2'($urandom_range(0, 3)) : bresp_mode;
      m_axi_bid    = 4'h3;
    end
  end

  always @(negedge aclk) begin
    cyc++;
    if (reset) begin
      m_phase = 0; m_ptr = 0; m_len = 0; m_beat = 0; m_cnt = 0;
      m_err = 1'b0; commit_exp = 1'b0; after_rst = 1'b1; aw_first = 1'b0; dut_beats = 0;
    end else begin
      if (after_rst) begin
        chk("rst_awvalid", m_axi_awvalid, 1'b0);
        chk("rst_wvalid", m_axi_wvalid, 1'b0);
        chk("rst_s_tready", s_tready, 1'b0);
        chk("rst_bready", m_axi_bready, 1'b0);
        chk("rst_bresp_err", bresp_err, 1'b0);
        after_rst = 1'b0;
      end
      chk("commit_valid", commit_valid, commit_exp);
      if (commit_exp) chk("commit_len", commit_len, commit_exp_len);
      if (commit_valid) begin
        cm_len_q.push_back(int'(commit_len));
        cm_cyc_q.push_back(cyc);
      end
      commit_exp = 1'b0;
      chk("bresp_err", bresp_err, m_err);
      chk("awvalid", m_axi_awvalid, m_phase == 1);
      chk("bready", m_axi_bready, m_phase == 3);
      if (s_tvalid && s_tready) pop_req = 1'b1;
      if (m_axi_bvalid && m_axi_bready) b_ack = 1'b1;
      if (m_phase != 2) begin
        chk("wvalid_idle", m_axi_wvalid, 1'b0);
        chk("s_tready_idle", s_tready, 1'b0);
      end
      case (m_phase)
        0: begin
          int a, f, r, l;
          bit go;
          a = int'(wr_words_avail);
          f = int'(mem_free_words);
          r = MB - (m_ptr % MB);
          l = MB;
          if (a < l) l = a;
          if (f < l) l = f;
          if (r < l) l = r;
          go = (l > 0) && (a >= MB || m_cnt == FD);
          if (go) begin
            m_phase = 1; m_len = l; m_cnt = 0; aw_first = 1'b1;
          end else if (a == 0) m_cnt = 0;
          else if (a < MB && m_cnt < FD) m_cnt++;
        end
        1: begin
          chk("awaddr", m_axi_awaddr, m_ptr * (W / 8));
          chk("awlen", m_axi_awlen, m_len - 1);
          chk("awid", m_axi_awid, 4'h3);
          chk("awsize", m_axi_awsize, 3'd4);
          chk("awburst", m_axi_awburst, 2'b01);
          chk("aw_zero_fields", {m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos}, 12'd0);
          chk("wstrb", m_axi_wstrb, {(W/8){1'b1}});
          if (aw_first) begin
            aw_addr_q.push_back(int'(m_axi_awaddr));
            aw_len_q.push_back(int'(m_axi_awlen));
            aw_cyc_q.push_back(cyc);
            $display("aw burst addr=0x%03h awlen=%0d cycle=%0d", m_axi_awaddr, m_axi_awlen, cyc);
            aw_first = 1'b0;
          end
          if (m_axi_awready) begin
            m_phase = 2; m_beat = 0; dut_beats = 0;
          end
        end
        2: begin
          chk("s_tready_eq_wready", s_tready, m_axi_wready);
          chk("wvalid_eq_tvalid", m_axi_wvalid, s_tvalid);
          if (m_axi_wvalid && m_axi_wready) begin
            chk("wdata", m_axi_wdata, (exp_q.size() > 0) ? exp_q[0] : {W{1'bx}});
            if (exp_q.size() > 0) exp_q.delete(0);
            chk("wlast", m_axi_wlast, m_beat == m_len - 1);
            dut_beats++;
            if (m_axi_wlast) beats_q.push_back(dut_beats);
            m_beat++;
            if (m_beat == m_len) begin
              m_phase = 3;
              b_pending++;
            end
          end
        end
        default: begin
          if (m_axi_bvalid) begin
            if (m_axi_bresp != 2'b00) m_err = 1'b1;
            commit_exp = 1'b1;
            commit_exp_len = m_len;
            m_ptr = (m_ptr + m_len) % MS;
            m_phase = 0;
            m_cnt = 0;
          end
        end
      endcase
    end
  end

  task automatic do_reset();
    @(posedge aclk); #2;
    reset = 1'b1;
    fifo_q.delete(); exp_q.delete();
    s_tvalid = 1'b0; m_axi_bvalid = 1'b0;
    b_pending = 0; pop_req = 1'b0; b_ack = 1'b0;
    @(posedge aclk); #2;
    reset = 1'b0;
    aw_addr_q.delete(); aw_len_q.delete(); aw_cyc_q.delete();
    cm_len_q.delete(); cm_cyc_q.delete(); beats_q.delete();
  endtask

  task automatic push_words(input int n);
    logic [W-1:0] w;
    @(negedge aclk); #2;
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic drain(input int max_cyc);
    int t = 0;
    @(negedge aclk); #3;
    while (!(fifo_q.size() == 0 && m_phase == 0 && !commit_exp) && t < max_cyc) begin
      @(negedge aclk); #3;
      t++;
    end
    chk("drain_in_time", t < max_cyc, 1'b1);
    repeat (2) @(negedge aclk);
    #3;
  endtask

  initial begin
    int t;
    reset = 1'b1;
    s_tvalid = 1'b0; s_tdata = '0; wr_words_avail = '0; mem_free_words = CW'(MS);
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_bresp = 2'b00; m_axi_bid = 4'h0;
    free_words = MS; tv_pct = 70; wr_pct = 70; rand_bresp = 1'b0; bresp_mode = 2'b00;
    b_pending = 0; pop_req = 1'b0; b_ack = 1'b0; cyc = 0;
    repeat (3) @(posedge aclk);
    #2 reset = 1'b0;

    // Backpressured 16-beat burst with a SLVERR response.
    do_reset();
    tv_pct = 50; wr_pct = 50; bresp_mode = 2'b10;
    push_words(16);
    drain(2000);
    chk("err_awaddr", aw_addr_q.size() > 0 ? aw_addr_q[0] : -1, 0);
    chk("err_awlen", aw_len_q.size() > 0 ? aw_len_q[0] : -1, 15);
    chk("err_beats", beats_q.size() > 0 ? beats_q[0] : -1, 16);
    chk("err_commit_len", cm_len_q.size() > 0 ? cm_len_q[0] : -1, 16);
    repeat (10) @(negedge aclk);
    chk("err_sticky", bresp_err, 1'b1);
    bresp_mode = 2'b00; tv_pct = 70; wr_pct = 70;

    // Reset after three beats, then restart from the ring base.
    do_reset();
    push_words(16);
    t = 0;
    while (!(m_phase == 2 && m_beat == 3) && t < 2000) begin
      @(negedge aclk); #3;
      t++;
    end
    chk("mid_burst_reached", t < 2000, 1'b1);
    do_reset();
    push_words(16);
    drain(2000);
    chk("post_rst_awaddr", aw_addr_q.size() > 0 ? aw_addr_q[0] : -1, 0);
    chk("post_rst_awlen", aw_len_q.size() > 0 ? aw_len_q[0] : -1, 15);

    // Two full bursts then a flushed partial one.
    do_reset();
    push_words(40);
    drain(3000);
    chk("full_n_bursts", aw_addr_q.size(), 3);
    if (aw_addr_q.size() >= 3 && cm_cyc_q.size() >= 2) begin
      chk("full0_addr", aw_addr_q[0], 32'h000);
      chk("full0_len", aw_len_q[0], 15);
      chk("full1_addr", aw_addr_q[1], 32'h100);
      chk("full1_len", aw_len_q[1], 15);
      chk("flush_addr", aw_addr_q[2], 32'h200);
      chk("flush_len", aw_len_q[2], 7);
      chk("flush_idle_cycles", aw_cyc_q[2] - cm_cyc_q[1] - 1, 32);
    end

    // Ring wrap from word 56.
    do_reset();
    push_words(56);
    drain(3000);
    push_words(16);
    drain(3000);
    chk("wrap_n_bursts", aw_addr_q.size(), 6);
    if (aw_addr_q.size() >= 6 && cm_len_q.size() >= 6) begin
      chk("wrap_pre_addr", aw_addr_q[3], 32'h300);
      chk("wrap_end_addr", aw_addr_q[4], 32'h380);
      chk("wrap_end_len", aw_len_q[4], 7);
      chk("wrap_base_addr", aw_addr_q[5], 32'h000);
      chk("wrap_base_len", aw_len_q[5], 7);
      chk("wrap_commit4", cm_len_q[4], 8);
      chk("wrap_commit5", cm_len_q[5], 8);
    end

    // Free space limits the burst.
    do_reset();
    free_words = 5;
    push_words(20);
    drain(4000);
    chk("free_awlen", aw_len_q.size() > 0 ? aw_len_q[0] : -1, 4);
    chk("free_beats", beats_q.size() > 0 ? beats_q[0] : -1, 5);
    free_words = MS;

    // Random traffic, free space and responses.
    do_reset();
    rand_bresp = 1'b1;
    for (int r = 0; r < 8; r++) begin
      tv_pct = $urandom_range(30, 100);
      wr_pct = $urandom_range(30, 100);
      free_words = $urandom_range(1, MS);
      push_words($urandom_range(1, 40));
      drain(6000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
